wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Commit-trace capture buffer that sits directly downstream of the CPU top's `debug_wb_*` writeback-trace outputs. Every cycle with a committed instruction, it normalises the WB record (pc, write enable, register, value) and pushes it into a circular FIFO. A valid/ready port lets a host-side consumer (UART dumper, compare checker) drain the FIFO at its own pace. It also keeps commit and drop counters plus a sticky overflow flag, so lost trace is always detectable.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `FILTER_NOWR`, 0: when 1, records whose normalised `ena` is 0 are not stored; they are still counted in `commit_cnt`.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `wb_have_inst`  in  1  WB stage holds a committing instruction this cycle.
- `wb_pc`  in  32  PC of the committing instruction.
- `wb_ena`  in  1  register-file write enable.
- `wb_reg`  in  5  destination register.
- `wb_value`  in  32  value written.
- `rec_valid`  out  1  head record available.
- `rec_ready`  in  1  consumer accepts the head record.
- `rec_pc` / `rec_ena` / `rec_reg` / `rec_value`  out  32/1/5/32  head record fields.
- `count`  out  $clog2(DEPTH)+1  entries currently stored.
- `overflow`  out  1  sticky: at least one record was dropped.
- `drop_cnt`  out  16  dropped records; saturates at 0xFFFF.
- `commit_cnt`  out  32  total `wb_have_inst` cycles; wraps modulo 2^32.
- `clear_stat`  in  1  clears `overflow` and `drop_cnt`.

## Operation
- Normalisation, applied at capture:
  - `ena_n = wb_ena & (wb_reg != 0)`.
  - If `ena_n` = 0, the stored reg and value are 0.
  - The pc is always stored as presented.
- Capture event: `wb_have_inst` = 1, and either `FILTER_NOWR` = 0 or `ena_n` = 1.
- Pop: `rec_valid & rec_ready` at the clock edge.
- FIFO not full: a capture event pushes at the write pointer.
- FIFO full (`count == DEPTH`):
  - With a simultaneous pop, the push is accepted and `count` stays at DEPTH.
  - Without a pop, the record is dropped, `overflow` is set to 1, and `drop_cnt` is incremented (saturating).
- Empty with a simultaneous push and `rec_ready` = 1: no bypass. The record appears on the next cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. `count` is tracked separately, which distinguishes full from empty.
- `commit_cnt` increments on every `wb_have_inst` = 1, regardless of filtering or dropping.
- `clear_stat` = 1 clears `overflow` and `drop_cnt`. If a drop happens in the same cycle, set wins: `overflow` = 1 and `drop_cnt` = 1.
- `rec_ready` while `rec_valid` = 0 has no effect.

## Timing
- Reset values: all outputs 0, meaning `rec_valid`, all `rec_*` fields, `count`, `overflow`, `drop_cnt` and `commit_cnt`. Pointers are 0. Storage contents are don't-care.
- Reset asserted mid-operation discards all stored records immediately (asynchronously).
- Capture latency: a record sampled at edge N is visible on `rec_*` with `rec_valid` = 1 after edge N, provided the FIFO was empty.
- `rec_*` come combinationally from the storage entry at the read pointer, and are forced to 0 while `rec_valid` = 0.
- Ordering: records are held stable while `rec_valid` = 1 and `rec_ready` = 0. After a pop at edge N, the next record (if any) is presented after edge N.
- Throughput: one push and one pop per cycle, sustained.
- `count`, `overflow`, `drop_cnt` and `commit_cnt` update at the same edge as the event that changes them.

## Structure
- Package `trace_pkg`:
  - `wb_rec_t` packed struct {pc[31:0], ena, reg[4:0], value[31:0]}, 70 bits.
  - Constants `TRACE_PC_W`, `TRACE_REG_W`, `TRACE_VAL_W`, `DROP_CNT_MAX` = 16'hFFFF.
- Sub-module `trace_fifo`: generic synchronous FIFO of `wb_rec_t`, with push, pop, full, empty and count.
- The top level holds normalisation, filtering, counters and the overflow logic.

## Test plan
- Reset then a single commit (pc=0x1000, ena=1, reg=5, value=0xDEADBEEF) with `rec_ready` = 0:
  - `rec_valid` = 1 one cycle later with the exact fields; `count` = 1; `commit_cnt` = 1.
- Commit with reg=0, ena=1, value=0x1234:
  - Stored record has ena=0, reg=0, value=0.
  - With `FILTER_NOWR` = 1 nothing is stored, but `commit_cnt` still increments.
- DEPTH=16, 20 consecutive commits with `rec_ready` = 0:
  - `count` = 16, `overflow` = 1, `drop_cnt` = 4.
  - The drain yields pc values of the first 16 commits in order.
- Full FIFO with push and pop in the same cycle:
  - `count` stays 16, no drop.
  - The next popped record is entry 2; the new record lands at the tail.
- `clear_stat` in the same cycle as a drop:
  - `overflow` = 1 and `drop_cnt` = 1 afterwards.
  - `clear_stat` alone on the next cycle gives `overflow` = 0 and `drop_cnt` = 0.
- Assert `rst_n` low asynchronously mid-stream with 7 entries stored:
  - All outputs 0 before the next clock edge.
  - After release, the first commit is again visible one cycle later.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and constants for the writeback commit-trace buffer.
// Provides the normalised trace record and a helper that builds it.
package trace_pkg;

   localparam int TRACE_PC_W  = 32;
   localparam int TRACE_REG_W = 5;
   localparam int TRACE_VAL_W = 32;

   localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

   // 70-bit record: pc, ena, rd, value (MSB to LSB)
   typedef struct packed {
      logic [TRACE_PC_W-1:0]  pc;
      logic                   ena;
      logic [TRACE_REG_W-1:0] rd;
      logic [TRACE_VAL_W-1:0] value;
   } wb_rec_t;

   // A write to x0 is not a write; its reg/value are zeroed
   function automatic wb_rec_t normalise(
      input logic [TRACE_PC_W-1:0]  pc,
      input logic                   ena,
      input logic [TRACE_REG_W-1:0] rd,
      input logic [TRACE_VAL_W-1:0] value
   );
      wb_rec_t r;
      logic    en;
      en      = ena & (rd != '0);
      r.pc    = pc;
      r.ena   = en;
      r.rd    = en ? rd : '0;
      r.value = en ? value : '0;
      return r;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular FIFO of trace records with separate occupancy count.
// Ports: i_push/i_pop/i_din in; o_dout, o_full, o_empty, o_count out.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  wb_rec_t       i_din,
   output wb_rec_t       o_dout,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   wb_rec_t       r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_MAX);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rptr];
   assign w_pop   = i_pop & ~o_empty;

   // Storage is not reset; contents are only observed when counted
   always_ff @(posedge clk) begin
      if (i_push)
         r_mem[r_wptr] <= i_din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push)
            r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)
            r_rptr <= r_rptr + PTR_ONE;
         unique case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wb_trace_buffer.sv
// Commit-trace capture: normalises WB records into a FIFO with drop stats.
// Ports: wb_* trace in, rec_* valid/ready out, count/overflow/counters.
module wb_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter bit FILTER_NOWR = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wb_have_inst,
   input  logic [31:0]              wb_pc,
   input  logic                     wb_ena,
   input  logic [4:0]               wb_reg,
   input  logic [31:0]              wb_value,
   output logic                     rec_valid,
   input  logic                     rec_ready,
   output logic [31:0]              rec_pc,
   output logic                     rec_ena,
   output logic [4:0]               rec_reg,
   output logic [31:0]              rec_value,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [15:0]              drop_cnt,
   output logic [31:0]              commit_cnt,
   input  logic                     clear_stat
);

   wb_rec_t w_rec;
   wb_rec_t w_head;
   logic    w_cap;
   logic    w_pop;
   logic    w_push;
   logic    w_drop;
   logic    w_full;
   logic    w_empty;

   logic        r_overflow;
   logic [15:0] r_drop_cnt;
   logic [31:0] r_commit_cnt;

   assign w_rec  = normalise(wb_pc, wb_ena, wb_reg, wb_value);
   assign w_cap  = wb_have_inst & (~FILTER_NOWR | w_rec.ena);
   assign w_pop  = ~w_empty & rec_ready;
   // A pop this edge frees the slot a full FIFO needs
   assign w_push = w_cap & (~w_full | w_pop);
   assign w_drop = w_cap & w_full & ~w_pop;

   trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_rec),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (count)
   );

   assign rec_valid = ~w_empty;
   assign rec_pc    = w_empty ? '0 : w_head.pc;
   assign rec_ena   = w_empty ? '0 : w_head.ena;
   assign rec_reg   = w_empty ? '0 : w_head.rd;
   assign rec_value = w_empty ? '0 : w_head.value;

   assign overflow   = r_overflow;
   assign drop_cnt   = r_drop_cnt;
   assign commit_cnt = r_commit_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow   <= 1'b0;
         r_drop_cnt   <= '0;
         r_commit_cnt <= '0;
      end else begin
         if (wb_have_inst)
            r_commit_cnt <= r_commit_cnt + 32'd1;
         // A drop beats a simultaneous clear
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_stat)
               r_drop_cnt <= 16'd1;
            else if (r_drop_cnt != DROP_CNT_MAX)
               r_drop_cnt <= r_drop_cnt + 16'd1;
         end else if (clear_stat) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Randomised scoreboard bench for wb_trace_buffer.
// Two instances: unfiltered (main) and FILTER_NOWR=1 (f_*).
module tb_wb_trace_buffer;

   localparam int D = 16;

   logic        clk;
   logic        rst_n;
   logic        wb_have_inst;
   logic [31:0] wb_pc;
   logic        wb_ena;
   logic [4:0]  wb_reg;
   logic [31:0] wb_value;
   logic        rec_ready;
   logic        clear_stat;

   logic        rec_valid;
   logic [31:0] rec_pc;
   logic        rec_ena;
   logic [4:0]  rec_reg;
   logic [31:0] rec_value;
   logic [4:0]  count;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic [31:0] commit_cnt;

   logic        f_valid;
   logic [31:0] f_pc;
   logic        f_ena;
   logic [4:0]  f_reg;
   logic [31:0] f_value;
   logic [4:0]  f_count;
   logic        f_overflow;
   logic [15:0] f_drop_cnt;
   logic [31:0] f_commit_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   logic [69:0] mq[$];
   logic [69:0] fq[$];
   logic        m_ovf;
   logic [15:0] m_drop;
   logic [31:0] m_commit;

   wb_trace_buffer #(.DEPTH(D), .FILTER_NOWR(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_have_inst(wb_have_inst), .wb_pc(wb_pc), .wb_ena(wb_ena),
      .wb_reg(wb_reg), .wb_value(wb_value),
      .rec_valid(rec_valid), .rec_ready(rec_ready),
      .rec_pc(rec_pc), .rec_ena(rec_ena), .rec_reg(rec_reg),
      .rec_value(rec_value), .count(count), .overflow(overflow),
      .drop_cnt(drop_cnt), .commit_cnt(commit_cnt),
      .clear_stat(clear_stat)
   );

   wb_trace_buffer #(.DEPTH(D), .FILTER_NOWR(1'b1)) dut_f (
      .clk(clk), .rst_n(rst_n),
      .wb_have_inst(wb_have_inst), .wb_pc(wb_pc), .wb_ena(wb_ena),
      .wb_reg(wb_reg), .wb_value(wb_value),
      .rec_valid(f_valid), .rec_ready(rec_ready),
      .rec_pc(f_pc), .rec_ena(f_ena), .rec_reg(f_reg),
      .rec_value(f_value), .count(f_count), .overflow(f_overflow),
      .drop_cnt(f_drop_cnt), .commit_cnt(f_commit_cnt),
      .clear_stat(clear_stat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [69:0] act,
                      input logic [69:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected stored form of a commit, from the normalisation rules
   function automatic logic [69:0] exp_rec(input logic [31:0] pc,
      input logic e, input logic [4:0] r, input logic [31:0] v);
      if (e && r != 5'd0)
         return {pc, 1'b1, r, v};
      return {pc, 1'b0, 5'd0, 32'd0};
   endfunction

   // Reference model: expected records pushed as stimulus is sampled
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         fq.delete();
         m_ovf    = 1'b0;
         m_drop   = 16'd0;
         m_commit = 32'd0;
      end else begin
         logic dropped;
         dropped = 1'b0;
         if (wb_have_inst) begin
            m_commit = m_commit + 32'd1;
            if (mq.size() < D)
               mq.push_back(exp_rec(wb_pc, wb_ena, wb_reg, wb_value));
            else
               dropped = 1'b1;
            if (wb_ena && wb_reg != 5'd0 && fq.size() < D)
               fq.push_back(exp_rec(wb_pc, wb_ena, wb_reg, wb_value));
         end
         if (dropped) begin
            m_ovf = 1'b1;
            if (clear_stat)
               m_drop = 16'd1;
            else if (m_drop != 16'hFFFF)
               m_drop = m_drop + 16'd1;
         end else if (clear_stat) begin
            m_ovf  = 1'b0;
            m_drop = 16'd0;
         end
      end
   end

   // Monitor: compare presented head, pop on handshake
   always @(negedge clk) begin
      chk("rec_valid", rec_valid, mq.size() != 0);
      chk("count", count, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("commit_cnt", commit_cnt, m_commit);
      if (mq.size() != 0)
         chk("rec_head", {rec_pc, rec_ena, rec_reg, rec_value}, mq[0]);
      else
         chk("rec_idle", {rec_pc, rec_ena, rec_reg, rec_value}, 70'd0);
      if (rec_valid && rec_ready && mq.size() != 0)
         void'(mq.pop_front());
      chk("f_count", f_count, fq.size());
      chk("f_commit", f_commit_cnt, m_commit);
      if (fq.size() != 0)
         chk("f_head", {f_pc, f_ena, f_reg, f_value}, fq[0]);
      if (f_valid && rec_ready && fq.size() != 0)
         void'(fq.pop_front());
   end

   task automatic cyc(input logic h, input logic [31:0] pc,
      input logic e, input logic [4:0] r, input logic [31:0] v,
      input logic rdy, input logic clr);
      wb_have_inst = h;
      wb_pc        = pc;
      wb_ena       = e;
      wb_reg       = r;
      wb_value     = v;
      rec_ready    = rdy;
      clear_stat   = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      wb_have_inst = 1'b0;
      wb_pc        = '0;
      wb_ena       = 1'b0;
      wb_reg       = '0;
      wb_value     = '0;
      rec_ready    = 1'b0;
      clear_stat   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", rec_valid, 1'b0);
      chk("rst_count", count, 5'd0);
      chk("rst_commit", commit_cnt, 32'd0);
      rst_n = 1'b1;

      cyc(1, 32'h1000, 1, 5'd5, 32'hDEADBEEF, 0, 0);
      chk("first_valid", rec_valid, 1'b1);
      chk("first_rec", {rec_pc, rec_ena, rec_reg, rec_value},
          {32'h1000, 1'b1, 5'd5, 32'hDEADBEEF});
      chk("first_count", count, 5'd1);
      chk("first_commit", commit_cnt, 32'd1);

      cyc(1, 32'h1004, 1, 5'd0, 32'h1234, 0, 0);
      chk("x0_count", count, 5'd2);
      chk("x0_fcount", f_count, 5'd1);
      chk("x0_fcommit", f_commit_cnt, 32'd2);
      cyc(0, 0, 0, 0, 0, 1, 0);
      chk("x0_rec", {rec_pc, rec_ena, rec_reg, rec_value},
          {32'h1004, 1'b0, 5'd0, 32'd0});
      repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);

      for (int i = 0; i < 20; i++)
         cyc(1, 32'h2000 + i, 1, 5'd7, i, 0, 0);
      chk("ovf_count", count, 5'd16);
      chk("ovf_flag", overflow, 1'b1);
      chk("ovf_drops", drop_cnt, 16'd4);

      cyc(1, 32'h3000, 1, 5'd3, 32'd7, 1, 0);
      chk("pp_count", count, 5'd16);
      chk("pp_drops", drop_cnt, 16'd4);
      chk("pp_head", rec_pc, 32'h2001);

      cyc(1, 32'h3004, 1, 5'd3, 32'd8, 0, 1);
      chk("clrdrop_ovf", overflow, 1'b1);
      chk("clrdrop_cnt", drop_cnt, 16'd1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("clr_ovf", overflow, 1'b0);
      chk("clr_cnt", drop_cnt, 16'd0);
      repeat (20) cyc(0, 0, 0, 0, 0, 1, 0);
      chk("drained", count, 5'd0);

      for (int i = 0; i < 3000; i++) begin
         logic       busy;
         logic [4:0] r;
         busy = ((i / 200) % 2) == 0;
         r    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         cyc($urandom_range(0, 3) != 0, $urandom, 1'($urandom), r,
             $urandom,
             busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
             $urandom_range(0, 49) == 0);
      end
      repeat (20) cyc(0, 0, 0, 0, 0, 1, 0);

      for (int i = 0; i < 7; i++)
         cyc(1, 32'h4000 + 4 * i, 1, 5'd9, i, 0, 0);
      chk("pre_rst_count", count, 5'd7);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", rec_valid, 1'b0);
      chk("arst_rec", {rec_pc, rec_ena, rec_reg, rec_value}, 70'd0);
      chk("arst_count", count, 5'd0);
      chk("arst_ovf", overflow, 1'b0);
      chk("arst_drop", drop_cnt, 16'd0);
      chk("arst_commit", commit_cnt, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1, 32'h5000, 1, 5'd1, 32'hAA, 0, 0);
      chk("post_rst_valid", rec_valid, 1'b1);
      chk("post_rst_pc", rec_pc, 32'h5000);
      chk("post_rst_count", count, 5'd1);
      repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
